// File: rtl/instruction_prefetch_buffer.sv
// instruction_prefetch_buffer
// Sequential instruction fetch with one outstanding req/ack transaction and a
// DEPTH-entry first-word-fall-through queue of {pc, instruction} pairs.
// A redirect flushes the queue and restarts fetch at the (word-aligned) target.
// Optional macro PREFETCH_STATS_EN adds saturating flush/discard counters.
module instruction_prefetch_buffer #(
   parameter int          DEPTH    = 4,
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   redirect_valid,
   input  logic [63:0]            redirect_pc,
   output logic                   mem_req,
   output logic [63:0]            mem_addr,
   input  logic                   mem_ack,
   input  logic [31:0]            mem_rdata,
   output logic                   inst_valid,
   output logic [63:0]            inst_pc,
   output logic [31:0]            inst_data,
   input  logic                   inst_ready,
   output logic [$clog2(DEPTH):0] occupancy
`ifdef PREFETCH_STATS_EN
   ,
   output logic [15:0]            flush_count,
   output logic [15:0]            discard_count
`endif
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [63:0]      fetch_pc_q, fetch_pc_d;
   logic [63:0]      mem_addr_q, mem_addr_d;
   logic             mem_req_q, mem_req_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [63:0]      fifo_pc_q   [DEPTH];
   logic [31:0]      fifo_data_q [DEPTH];

   logic [63:0]      redirect_tgt_s;
   logic [63:0]      next_seq_s;
   logic             ack_s;
   logic             pop_s;
   logic             push_s;
   logic             space_s;
   logic             unused_redirect_lsb_s;

   // Instructions are word aligned, so the two low target bits carry no information.
   assign redirect_tgt_s        = {redirect_pc[63:2], 2'b00};
   assign unused_redirect_lsb_s = ^redirect_pc[1:0];
   assign next_seq_s            = mem_addr_q + 64'd4;
   assign ack_s                 = mem_req_q & mem_ack;
   assign pop_s                 = inst_valid & inst_ready & ~redirect_valid;
   // Only an ack in WAIT without a concurrent redirect carries wanted data.
   assign push_s                = (state_q == ST_WAIT) & ack_s & ~redirect_valid;
   assign space_s               = (count_d < DEPTH_C);

   assign mem_req    = mem_req_q;
   assign mem_addr   = mem_addr_q;
   assign inst_valid = (count_q != {CNT_W{1'b0}});
   assign inst_pc    = fifo_pc_q[rd_ptr_q];
   assign inst_data  = fifo_data_q[rd_ptr_q];
   assign occupancy  = count_q;

   // Queue bookkeeping: a redirect empties the queue, otherwise push/pop move pointers and count.
   always_comb begin
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (redirect_valid) begin
         count_d  = {CNT_W{1'b0}};
         wr_ptr_d = {PTR_W{1'b0}};
         rd_ptr_d = {PTR_W{1'b0}};
      end else begin
         if (push_s) wr_ptr_d = wr_ptr_q + PTR_ONE;
         else        wr_ptr_d = wr_ptr_q;
         if (pop_s)  rd_ptr_d = rd_ptr_q + PTR_ONE;
         else        rd_ptr_d = rd_ptr_q;
         if (push_s && !pop_s)      count_d = count_q + CNT_ONE;
         else if (!push_s && pop_s) count_d = count_q - CNT_ONE;
         else                       count_d = count_q;
      end
   end

   // Fetch FSM next state: issue when there is room, drain an abandoned request after a redirect.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (redirect_valid || space_s) state_d = ST_WAIT;
            else                           state_d = ST_IDLE;
         end
         ST_WAIT: begin
            if (ack_s) begin
               if (redirect_valid || space_s) state_d = ST_WAIT;
               else                           state_d = ST_IDLE;
            end else if (redirect_valid) begin
               state_d = ST_DRAIN;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_DRAIN: begin
            if (ack_s) state_d = ST_WAIT;
            else       state_d = ST_DRAIN;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Fetch FSM outputs: next fetch pc, next request address, and request strobe.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      mem_addr_d = mem_addr_q;
      case (state_q)
         ST_IDLE: begin
            if (redirect_valid) begin
               fetch_pc_d = redirect_tgt_s;
               mem_addr_d = redirect_tgt_s;
            end else if (space_s) begin
               mem_addr_d = fetch_pc_q;
            end else begin
               mem_addr_d = mem_addr_q;
            end
         end
         ST_WAIT: begin
            if (ack_s && !redirect_valid) begin
               fetch_pc_d = next_seq_s;
               mem_addr_d = next_seq_s;
            end else if (redirect_valid) begin
               fetch_pc_d = redirect_tgt_s;
               // Without an ack the request must stay on the bus unchanged.
               if (ack_s) mem_addr_d = redirect_tgt_s;
               else       mem_addr_d = mem_addr_q;
            end else begin
               fetch_pc_d = fetch_pc_q;
            end
         end
         ST_DRAIN: begin
            if (redirect_valid) fetch_pc_d = redirect_tgt_s;
            else                fetch_pc_d = fetch_pc_q;
            if (ack_s) mem_addr_d = redirect_valid ? redirect_tgt_s : fetch_pc_q;
            else       mem_addr_d = mem_addr_q;
         end
         default: begin
            fetch_pc_d = RESET_PC;
            mem_addr_d = RESET_PC;
         end
      endcase
      mem_req_d = (state_d != ST_IDLE);
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Fetch datapath and queue control registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC;
         mem_addr_q <= RESET_PC;
         mem_req_q  <= 1'b0;
         count_q    <= {CNT_W{1'b0}};
         wr_ptr_q   <= {PTR_W{1'b0}};
         rd_ptr_q   <= {PTR_W{1'b0}};
      end else begin
         fetch_pc_q <= fetch_pc_d;
         mem_addr_q <= mem_addr_d;
         mem_req_q  <= mem_req_d;
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   // Queue storage; contents are only meaningful below the count, so no reset is needed.
   always_ff @(posedge clk) begin
      if (push_s) begin
         fifo_pc_q[wr_ptr_q]   <= mem_addr_q;
         fifo_data_q[wr_ptr_q] <= mem_rdata;
      end
   end

`ifdef PREFETCH_STATS_EN
   logic [15:0] flush_count_q, flush_count_d;
   logic [15:0] discard_count_q, discard_count_d;
   logic        discard_s;

   assign discard_s     = ack_s & ((state_q == ST_DRAIN) | redirect_valid);
   assign flush_count   = flush_count_q;
   assign discard_count = discard_count_q;

   // Saturating event counters for redirects and dropped fetch data.
   always_comb begin
      if (redirect_valid && (flush_count_q != 16'hFFFF)) flush_count_d = flush_count_q + 16'd1;
      else                                                flush_count_d = flush_count_q;
      if (discard_s && (discard_count_q != 16'hFFFF)) discard_count_d = discard_count_q + 16'd1;
      else                                             discard_count_d = discard_count_q;
   end

   // Statistics counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         flush_count_q   <= 16'd0;
         discard_count_q <= 16'd0;
      end else begin
         flush_count_q   <= flush_count_d;
         discard_count_q <= discard_count_d;
      end
   end
`endif

endmodule

// File: doc/instruction_prefetch_buffer.md
Name: instruction_prefetch_buffer

Overview:
- Fetch stage that sits directly upstream of the single-cycle RISC-V core; replaces direct combinational instruction-memory lookup.
- Issues sequential 32-bit fetches to instruction memory over a req/ack handshake, allowing at most one request outstanding at a time.
- Queues fetched {pc, instruction} pairs in a DEPTH-entry FIFO and presents the head to decode with a valid/ready handshake.
- On a taken branch/jump, a redirect flushes the queue and restarts fetch at the target.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- RESET_PC, 64'h0, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- redirect_valid  in  1  flush the queue and restart fetch at redirect_pc.
- redirect_pc  in  64  redirect target; bits [1:0] are forced to 0 internally.
- mem_req  out  1  fetch request; registered.
- mem_addr  out  64  fetch address; registered; held stable while mem_req=1.
- mem_ack  in  1  memory accepts the request and returns mem_rdata in the same cycle; meaningful only when mem_req=1.
- mem_rdata  in  32  fetched instruction.
- inst_valid  out  1  FIFO head is valid (count != 0).
- inst_pc  out  64  pc of the FIFO head.
- inst_data  out  32  instruction at the FIFO head.
- inst_ready  in  1  decode consumes the head when inst_valid & inst_ready.
- occupancy  out  $clog2(DEPTH)+1  current FIFO count.

Behaviour:
- Reset values: state=IDLE, fetch_pc=RESET_PC, mem_addr=RESET_PC, mem_req=0, count=0, inst_valid=0, FIFO pointers=0.
  - inst_pc and inst_data are don't-care while inst_valid=0.
- FIFO:
  - First-word-fall-through; head visible combinationally from storage.
  - pop = inst_valid & inst_ready & ~redirect_valid.
  - push = an accepted, non-discarded ack.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
- Definitions:
  - count_next = count after this cycle's push, pop and flush.
  - space = (count_next < DEPTH).
- State IDLE (mem_req=0):
  - redirect: fetch_pc <= redirect_pc; flush; go to WAIT with mem_addr=redirect_pc.
  - else if space: go to WAIT with mem_addr=fetch_pc.
- State WAIT (mem_req=1, mem_addr stable):
  - ack & ~redirect: push {mem_addr, mem_rdata}; fetch_pc <= mem_addr+4 (wraps modulo 2^64).
    - If space: stay in WAIT with mem_addr=mem_addr+4, giving back-to-back fetch of 1 instruction/cycle.
    - Else: go to IDLE.
  - ack & redirect: discard the data; flush; fetch_pc <= redirect_pc; stay in WAIT with mem_addr=redirect_pc.
  - ~ack & redirect: flush; fetch_pc <= redirect_pc; go to DRAIN. mem_req and mem_addr stay unchanged (handshake is never withdrawn).
  - ~ack & ~redirect: hold.
- State DRAIN (mem_req=1, stale mem_addr):
  - ack: discard the data; go to WAIT with mem_addr=fetch_pc, or with redirect_pc if a redirect arrives in the same cycle.
  - ~ack & redirect: fetch_pc <= redirect_pc; stay in DRAIN.
- Redirect has priority over pop and push in the same cycle; inst_valid=0 the cycle after any redirect.
- Overflow is impossible: a request is issued only when space holds, and at most one request is outstanding.
- Reset asserted mid-request:
  - Returns to IDLE and drops mem_req.
  - Memory must tolerate an abandoned request.

Optional Feature:
- Macro PREFETCH_STATS_EN.
- Defined:
  - Adds outputs flush_count[15:0] and discard_count[15:0], both reset to 0 and saturating at 16'hFFFF.
  - flush_count increments on every redirect_valid.
  - discard_count increments on every ack whose data is dropped (ack in DRAIN, or ack together with redirect).
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release, mem_ack tied high, inst_ready=1 -> mem_req=1 with mem_addr=0 one cycle after reset; inst_pc sequence 0,4,8,... one per cycle; inst_data matches memory.
- inst_ready=0, ack always high, DEPTH=4 -> occupancy reaches 4; mem_req drops to 0; no further pushes. Raising inst_ready resumes fetch at 0x10.
- Redirect to 0x1003 while WAIT awaits ack, ack 3 cycles later -> state DRAIN; the late ack data is not queued; next mem_addr=0x1000; first inst_pc=0x1000.
- Redirect in the same cycle as ack and a pop -> queue emptied; no push; mem_addr=redirect target next cycle; inst_valid=0 next cycle.
- fetch_pc=64'hFFFF_FFFF_FFFF_FFFC with ack -> next mem_addr=0 (wrap).
- With PREFETCH_STATS_EN, 2 redirects of which 1 lands during DRAIN -> flush_count=2, discard_count=1.
